fifo_packer: RTL and testbench

Downstream consumer for the 2-bit FiFo. It pops narrow entries from the FIFO's read port and packs PACK consecutive entries into one wide word. It presents that word on a valid/ready output handshake to the next stage. A flush input closes a partially filled word so that trailing data is never stranded.

---
 rtl/fifo_packer.sv | 79 +++++++
 tb/tb_fifo_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// +----------------------------------------------------------------------------+
// | fifo_packer: pops narrow FIFO entries and packs PACK of them into one wide |
// | word on a valid/ready output; flush closes a partially filled word.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_packer #(
  parameter int DATA_WIDTH = 2,
  parameter int PACK       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         io_fifo_dout,
  input  logic                          io_fifo_empty,
  output logic                          io_fifo_pop,
  input  logic                          io_flush,
  output logic [DATA_WIDTH*PACK-1:0]    io_data,
  output logic [$clog2(PACK+1)-1:0]     io_count,
  output logic                          io_valid,
  input  logic                          io_ready
);

  localparam int CNT_W = $clog2(PACK+1);

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH*PACK-1:0] word_q, word_d;
  logic                       closed_q, closed_d;
  logic                       fire;

  assign fire        = closed_q & io_ready;
  // Reset gates the pop so the FIFO never loses an entry while we are held in reset.
  assign io_fifo_pop = reset & ~io_fifo_empty & ~io_flush & (~closed_q | io_ready);

  assign io_data  = word_q;
  assign io_count = cnt_q;
  assign io_valid = closed_q;

  always_comb begin
    cnt_d    = cnt_q;
    word_d   = word_q;
    closed_d = closed_q;
    if (fire && io_fifo_pop) begin
      word_d                 = '0;
      word_d[DATA_WIDTH-1:0] = io_fifo_dout;
      cnt_d                  = CNT_W'(1);
      closed_d               = 1'b0;
    end else if (fire) begin
      word_d   = '0;
      cnt_d    = '0;
      closed_d = 1'b0;
    end else if (io_fifo_pop) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          word_d[i*DATA_WIDTH +: DATA_WIDTH] = io_fifo_dout;
        end
      end
      cnt_d    = cnt_q + CNT_W'(1);
      closed_d = (cnt_q == CNT_W'(PACK-1));
    end else if (io_flush && (cnt_q != '0) && !closed_q) begin
      closed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      word_q   <= '0;
      closed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      closed_q <= closed_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_packer.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_packer: directed scoreboard bench for fifo_packer (DW=2, PACK=4).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] io_fifo_dout = '0;
  logic       io_fifo_empty = 1'b1;
  logic       io_fifo_pop;
  logic       io_flush = 1'b0;
  logic [7:0] io_data;
  logic [2:0] io_count;
  logic       io_valid;
  logic       io_ready = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] c;
  } exp_t;

  logic [1:0] fq[$];
  exp_t       sb[$];
  logic       force_empty = 1'b0;
  int         total = 0;
  int         bad = 0;

  fifo_packer #(.DATA_WIDTH(2), .PACK(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_fifo_dout (io_fifo_dout),
    .io_fifo_empty(io_fifo_empty),
    .io_fifo_pop  (io_fifo_pop),
    .io_flush     (io_flush),
    .io_data      (io_data),
    .io_count     (io_count),
    .io_valid     (io_valid),
    .io_ready     (io_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    io_fifo_empty = force_empty || (fq.size() == 0);
    io_fifo_dout  = (fq.size() != 0) ? fq[0] : 2'b00;
  endtask

  task automatic settle();
    refresh();
    #1;
  endtask

  // One clock: model the FIFO pop and score any word that fired at this edge.
  task automatic tick();
    logic p, f;
    logic [7:0] d;
    logic [2:0] c;
    exp_t e;
    p = io_fifo_pop;
    f = io_valid & io_ready;
    d = io_data;
    c = io_count;
    @(posedge clk);
    if (p && fq.size() != 0) void'(fq.pop_front());
    if (f) begin
      if (sb.size() == 0) begin
        chk("unexpected_fire", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("fire_data", {24'h0, d}, {24'h0, e.d});
        chk("fire_count", {29'h0, c}, {29'h0, e.c});
      end
    end
    #1;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with a loaded FIFO
    #1 reset = 1'b0;
    fq.push_back(2'd1); fq.push_back(2'd2); fq.push_back(2'd3); fq.push_back(2'd0);
    sb.push_back('{d: 8'h39, c: 3'd4});
    settle();
    chk("rst_pop", io_fifo_pop, 0);
    chk("rst_valid", io_valid, 0);
    chk("rst_count", io_count, 0);
    chk("rst_data", io_data, 0);
    @(negedge clk);
    reset = 1'b1;
    settle();

    // Basic packing
    for (int k = 0; k < 4; k++) begin
      chk("basic_pop", io_fifo_pop, 1);
      tick();
    end
    chk("basic_valid", io_valid, 1);
    chk("basic_data", io_data, 32'h39);
    chk("basic_count", io_count, 4);

    // Backpressure with a non-empty FIFO
    for (int k = 0; k < 4; k++) fq.push_back(2'd3);
    for (int k = 0; k < 4; k++) fq.push_back(2'd1);
    sb.push_back('{d: 8'hFF, c: 3'd4});
    sb.push_back('{d: 8'h55, c: 3'd4});
    settle();
    for (int k = 0; k < 5; k++) begin
      chk("bp_pop", io_fifo_pop, 0);
      chk("bp_data", io_data, 32'h39);
      chk("bp_valid", io_valid, 1);
      tick();
    end
    io_ready = 1'b1;
    settle();
    chk("bp_pop_on_ready", io_fifo_pop, 1);

    // Streaming across a word boundary
    for (int k = 1; k <= 8; k++) begin
      chk("stream_pop", io_fifo_pop, 1);
      tick();
      if (k == 1) chk("bp_cnt_after_fire", io_count, 1);
      chk("stream_valid", io_valid, (k == 4 || k == 8) ? 1 : 0);
    end
    chk("drain_pop", io_fifo_pop, 0);
    tick();
    chk("drain_valid", io_valid, 0);
    chk("drain_count", io_count, 0);
    chk("drain_data", io_data, 0);

    // Flush with nothing collected
    io_flush = 1'b1;
    settle();
    tick();
    io_flush = 1'b0;
    settle();
    chk("flush_empty_valid", io_valid, 0);

    // Flush of a partial word
    io_ready = 1'b0;
    fq.push_back(2'd2); fq.push_back(2'd1); fq.push_back(2'd3);
    sb.push_back('{d: 8'h06, c: 3'd2});
    settle();
    tick();
    tick();
    io_flush = 1'b1;
    settle();
    chk("flush_pop", io_fifo_pop, 0);
    tick();
    io_flush = 1'b0;
    settle();
    chk("flush_valid", io_valid, 1);
    chk("flush_data", io_data, 32'h06);
    chk("flush_count", io_count, 2);
    io_flush = 1'b1;
    settle();
    tick();
    io_flush = 1'b0;
    settle();
    chk("flush_closed_count", io_count, 2);
    chk("flush_closed_data", io_data, 32'h06);
    io_ready = 1'b1;
    settle();
    chk("flush_fire_pop", io_fifo_pop, 1);
    tick();
    io_ready = 1'b0;
    settle();
    chk("after_flush_count", io_count, 1);
    chk("after_flush_data", io_data, 32'h03);
    chk("after_flush_valid", io_valid, 0);

    // FIFO empty mid-word
    force_empty = 1'b1;
    fq.push_back(2'd1); fq.push_back(2'd2); fq.push_back(2'd3);
    sb.push_back('{d: 8'hE7, c: 3'd4});
    settle();
    for (int k = 0; k < 10; k++) begin
      chk("empty_pop", io_fifo_pop, 0);
      tick();
      chk("empty_count", io_count, 1);
      chk("empty_data", io_data, 32'h03);
    end
    force_empty = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) tick();
    chk("refill_valid", io_valid, 1);
    chk("refill_data", io_data, 32'hE7);
    io_ready = 1'b1;
    settle();
    tick();
    io_ready = 1'b0;
    settle();
    chk("refill_fired", io_valid, 0);

    // Asynchronous reset mid-word
    fq.push_back(2'd1); fq.push_back(2'd2); fq.push_back(2'd3); fq.push_back(2'd2);
    settle();
    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_count", io_count, 3);
    chk("pre_rst_data", io_data, 32'h39);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", io_valid, 0);
    chk("arst_count", io_count, 0);
    chk("arst_data", io_data, 0);
    chk("arst_pop", io_fifo_pop, 0);
    @(negedge clk);
    reset = 1'b1;
    fq.push_back(2'd1); fq.push_back(2'd1); fq.push_back(2'd1);
    sb.push_back('{d: 8'h56, c: 3'd4});
    settle();
    for (int k = 0; k < 4; k++) tick();
    chk("post_rst_valid", io_valid, 1);
    chk("post_rst_data", io_data, 32'h56);
    io_ready = 1'b1;
    settle();
    tick();
    chk("sb_empty", sb.size(), 0);
    chk("fq_empty", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
